// File: rtl/ppm_frame_rx.sv
// Pulse-position frame receiver: wake pulses, an N_BITS payload (optionally
// followed by an even-parity symbol), then an arm/scan/fire loop with timeouts.
module ppm_frame_rx #(
  parameter int N_BITS       = 4,
  parameter int WAKE_PULSES  = 3,
  parameter int SHORT_MAX    = 4,
  parameter int LONG_MIN     = 6,
  parameter int TIMEOUT      = 10,
  parameter int SCAN_TIMEOUT = 0,
  parameter int PARITY       = 0
) (
  input  logic              CLK_IN,
  input  logic              rst_n,
  input  logic              DATA_IN,
  output logic [3:0]        state,
  output logic [N_BITS-1:0] amplitude,
  output logic              amp_valid,
  output logic              fire,
  output logic              frame_err,
  output logic              timeout,
  output logic              GLED5,
  output logic              RLED1,
  output logic              RLED2,
  output logic              RLED3,
  output logic              RLED4
);
  localparam int TOT  = N_BITS + PARITY;
  localparam int GMAX = (SCAN_TIMEOUT > TIMEOUT) ? SCAN_TIMEOUT : TIMEOUT;
  localparam int CW   = $clog2(GMAX + 1);
  // A marker bit rides above the received bits; reaching bit TOT means the frame is full.
  localparam logic [TOT:0] SHIFT_EMPTY = {{TOT{1'b0}}, 1'b1};

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_WAKE  = 4'd1,
    S_DATA  = 4'd3,
    S_SYM_B = 4'd4,
    S_SYM_C = 4'd5,
    S_ARM   = 4'd7,
    S_SCAN  = 4'd8,
    S_FIRE  = 4'd9
  } state_t;

  typedef enum logic [1:0] {G_SHORT = 2'd0, G_LONG = 2'd1, G_ERR = 2'd2} gap_t;

  state_t              r_state, w_state_nxt;
  gap_t                r_g1, w_g1_nxt, w_class;
  logic                r_d_q;
  logic [CW-1:0]       r_gap;
  logic [3:0]          r_wake, w_wake_nxt;
  logic [TOT:0]        r_shift, w_shift_nxt, w_word;
  logic [N_BITS-1:0]   r_amp, w_amp_nxt;
  logic                r_amp_valid, w_valid_nxt;
  logic                r_frame_err, w_ferr_nxt;
  logic                r_timeout, w_tout_nxt;
  logic                r_fire;
  logic                w_pulse, w_sym_ok, w_bit, w_tmo;

  function automatic logic f_even_parity_ok(input logic [TOT-1:0] word);
    return (PARITY == 0) || (^word == 1'b0);
  endfunction

  assign w_pulse = DATA_IN & ~r_d_q;

  // Edge-detect register and saturating gap counter
  always_ff @(posedge CLK_IN or negedge rst_n) begin
    if (!rst_n) begin
      r_d_q <= 1'b0;
      r_gap <= '0;
    end else begin
      r_d_q <= DATA_IN;
      if (w_pulse) begin
        r_gap <= CW'(1);
      end else if (r_gap != CW'(GMAX)) begin
        r_gap <= r_gap + CW'(1);
      end else begin
        r_gap <= r_gap;
      end
    end
  end

  // Gap classification and timeout thresholds for the current state
  always_comb begin
    w_class = G_ERR;
    w_tmo   = 1'b0;
    if (r_gap <= CW'(SHORT_MAX)) begin
      w_class = G_SHORT;
    end else if ((r_gap >= CW'(LONG_MIN)) && (r_gap < CW'(TIMEOUT))) begin
      w_class = G_LONG;
    end else begin
      w_class = G_ERR;
    end
    case (r_state)
      S_WAKE, S_DATA, S_SYM_B, S_SYM_C, S_ARM: w_tmo = (r_gap == CW'(TIMEOUT));
      S_SCAN, S_FIRE: w_tmo = (SCAN_TIMEOUT != 0) && (r_gap == CW'(SCAN_TIMEOUT));
      default:        w_tmo = 1'b0;
    endcase
  end

  // Next-state and datapath decisions; a pulse takes priority over a timeout
  always_comb begin
    w_state_nxt = r_state;
    w_wake_nxt  = r_wake;
    w_shift_nxt = r_shift;
    w_g1_nxt    = r_g1;
    w_amp_nxt   = r_amp;
    w_valid_nxt = r_amp_valid;
    w_ferr_nxt  = 1'b0;
    w_tout_nxt  = 1'b0;
    w_sym_ok    = ((r_g1 == G_SHORT) && (w_class == G_LONG)) ||
                  ((r_g1 == G_LONG) && (w_class == G_SHORT));
    w_bit       = (r_g1 == G_LONG);
    w_word      = {r_shift[TOT-1:0], w_bit};
    if (w_pulse) begin
      case (r_state)
        S_IDLE: begin
          w_wake_nxt = 4'd1;
          if (WAKE_PULSES == 1) w_state_nxt = S_DATA;
          else                  w_state_nxt = S_WAKE;
        end
        S_WAKE: begin
          w_wake_nxt = r_wake + 4'd1;
          if ((r_wake + 4'd1) == 4'(WAKE_PULSES)) w_state_nxt = S_DATA;
          else                                     w_state_nxt = S_WAKE;
        end
        S_DATA: begin
          if (r_shift[TOT]) begin
            w_state_nxt = S_ARM;
            w_shift_nxt = SHIFT_EMPTY;
          end else begin
            w_state_nxt = S_SYM_B;
          end
        end
        S_SYM_B: begin
          w_g1_nxt    = w_class;
          w_state_nxt = S_SYM_C;
        end
        S_SYM_C: begin
          if (!w_sym_ok || (w_word[TOT] && !f_even_parity_ok(w_word[TOT-1:0]))) begin
            w_ferr_nxt  = 1'b1;
            w_state_nxt = S_IDLE;
            w_shift_nxt = SHIFT_EMPTY;
          end else if (w_word[TOT]) begin
            w_amp_nxt   = w_word[TOT-1 -: N_BITS];
            w_valid_nxt = 1'b1;
            w_shift_nxt = w_word;
            w_state_nxt = S_DATA;
          end else begin
            w_shift_nxt = w_word;
            w_state_nxt = S_DATA;
          end
        end
        S_ARM:   w_state_nxt = S_SCAN;
        S_SCAN:  w_state_nxt = S_FIRE;
        S_FIRE:  w_state_nxt = S_SCAN;
        default: w_state_nxt = S_IDLE;
      endcase
    end else if (w_tmo) begin
      w_state_nxt = S_IDLE;
      w_tout_nxt  = 1'b1;
      w_shift_nxt = SHIFT_EMPTY;
    end else begin
      w_state_nxt = r_state;
    end
  end

  // State, payload and status registers
  always_ff @(posedge CLK_IN or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_wake      <= 4'd0;
      r_shift     <= SHIFT_EMPTY;
      r_g1        <= G_SHORT;
      r_amp       <= '0;
      r_amp_valid <= 1'b0;
      r_frame_err <= 1'b0;
      r_timeout   <= 1'b0;
      r_fire      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_wake      <= w_wake_nxt;
      r_shift     <= w_shift_nxt;
      r_g1        <= w_g1_nxt;
      r_amp       <= w_amp_nxt;
      r_amp_valid <= w_valid_nxt;
      r_frame_err <= w_ferr_nxt;
      r_timeout   <= w_tout_nxt;
      r_fire      <= (w_state_nxt == S_FIRE);
    end
  end

  assign state     = r_state;
  assign amplitude = r_amp;
  assign amp_valid = r_amp_valid;
  assign fire      = r_fire;
  assign frame_err = r_frame_err;
  assign timeout   = r_timeout;
  assign GLED5     = r_amp_valid;
  assign RLED1     = r_state[0];
  assign RLED2     = r_state[1];
  assign RLED3     = r_state[2];
  assign RLED4     = r_state[3];
endmodule

// File: tb/tb_ppm_frame_rx.sv
// Bench for ppm_frame_rx: three configurations (defaults, parity, 8-bit with
// scan timeout) checked every cycle against an event-level frame model.
module tb_ppm_frame_rx;
  localparam int P_IDLE = 0, P_WAKE = 1, P_DATA = 2, P_SB = 3, P_SC = 4,
                 P_ARM = 5, P_SCAN = 6, P_FIRE = 7;
  localparam int C_S = 0, C_L = 1, C_E = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic d [3];
  int   checks = 0;
  int   errors = 0;

  wire [3:0] o_st [3];
  wire [3:0] o_led [3];
  wire       o_valid [3];
  wire       o_fire [3];
  wire       o_ferr [3];
  wire       o_tout [3];
  wire       o_gled [3];
  wire [3:0] amp0, amp1;
  wire [7:0] amp2;

  initial forever #5 clk = ~clk;

  ppm_frame_rx u_def (
    .CLK_IN(clk), .rst_n(rst_n), .DATA_IN(d[0]), .state(o_st[0]), .amplitude(amp0),
    .amp_valid(o_valid[0]), .fire(o_fire[0]), .frame_err(o_ferr[0]), .timeout(o_tout[0]),
    .GLED5(o_gled[0]), .RLED1(o_led[0][0]), .RLED2(o_led[0][1]), .RLED3(o_led[0][2]),
    .RLED4(o_led[0][3]));

  ppm_frame_rx #(.PARITY(1)) u_par (
    .CLK_IN(clk), .rst_n(rst_n), .DATA_IN(d[1]), .state(o_st[1]), .amplitude(amp1),
    .amp_valid(o_valid[1]), .fire(o_fire[1]), .frame_err(o_ferr[1]), .timeout(o_tout[1]),
    .GLED5(o_gled[1]), .RLED1(o_led[1][0]), .RLED2(o_led[1][1]), .RLED3(o_led[1][2]),
    .RLED4(o_led[1][3]));

  ppm_frame_rx #(.N_BITS(8), .SCAN_TIMEOUT(30)) u_n8 (
    .CLK_IN(clk), .rst_n(rst_n), .DATA_IN(d[2]), .state(o_st[2]), .amplitude(amp2),
    .amp_valid(o_valid[2]), .fire(o_fire[2]), .frame_err(o_ferr[2]), .timeout(o_tout[2]),
    .GLED5(o_gled[2]), .RLED1(o_led[2][0]), .RLED2(o_led[2][1]), .RLED3(o_led[2][2]),
    .RLED4(o_led[2][3]));

  function automatic int nb_of(input int i);   return (i == 2) ? 8 : 4;  endfunction
  function automatic int par_of(input int i);  return (i == 1) ? 1 : 0;  endfunction
  function automatic int sto_of(input int i);  return (i == 2) ? 30 : 0; endfunction
  function automatic int gmax_of(input int i); return (sto_of(i) > 10) ? sto_of(i) : 10; endfunction

  function automatic int amp_act(input int i);
    case (i)
      0:       return int'(amp0);
      1:       return int'(amp1);
      default: return int'(amp2);
    endcase
  endfunction

  // Visible state code for each model phase.
  function automatic int st_of(input int ph);
    case (ph)
      P_IDLE:  return 0;
      P_WAKE:  return 1;
      P_DATA:  return 3;
      P_SB:    return 4;
      P_SC:    return 5;
      P_ARM:   return 7;
      P_SCAN:  return 8;
      default: return 9;
    endcase
  endfunction

  function automatic int cls(input int gap);
    if (gap <= 4) return C_S;
    else if (gap >= 6 && gap < 10) return C_L;
    else return C_E;
  endfunction

  task automatic chk(input string nm, input int inst, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s inst=%0d actual=%0d required=%0d t=%0t", nm, inst, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_phase [3], m_wake [3], m_last [3], m_nbits [3], m_word [3], m_g1 [3], m_amp [3];
  bit m_prev [3], m_valid [3], m_ferr [3], m_tout [3];
  int edge_n = 0;

  task automatic mdl_abort(input int i);
    m_phase[i] = P_IDLE;
    m_word[i]  = 0;
    m_nbits[i] = 0;
  endtask

  task automatic mdl_reset();
    for (int i = 0; i < 3; i++) begin
      mdl_abort(i);
      m_wake[i] = 0; m_last[i] = edge_n; m_g1[i] = C_S; m_amp[i] = 0;
      m_prev[i] = 1'b0; m_valid[i] = 1'b0; m_ferr[i] = 1'b0; m_tout[i] = 1'b0;
    end
  endtask

  task automatic mdl_step(input int i);
    int gap; bit pulse; int g2; int bitv;
    pulse = d[i] && !m_prev[i];
    m_prev[i] = d[i];
    gap = edge_n - m_last[i];
    if (gap > gmax_of(i)) gap = gmax_of(i);
    if (pulse) m_last[i] = edge_n;
    m_ferr[i] = 1'b0;
    m_tout[i] = 1'b0;
    if (pulse) begin
      case (m_phase[i])
        P_IDLE: begin m_wake[i] = 1; m_phase[i] = P_WAKE; end
        P_WAKE: begin m_wake[i]++; if (m_wake[i] == 3) m_phase[i] = P_DATA; end
        P_DATA: begin
          if (m_nbits[i] == nb_of(i) + par_of(i)) begin
            mdl_abort(i);
            m_phase[i] = P_ARM;
          end else m_phase[i] = P_SB;
        end
        P_SB: begin m_g1[i] = cls(gap); m_phase[i] = P_SC; end
        P_SC: begin
          g2 = cls(gap);
          if (m_g1[i] == C_S && g2 == C_L) bitv = 0;
          else if (m_g1[i] == C_L && g2 == C_S) bitv = 1;
          else bitv = -1;
          if (bitv < 0) begin
            m_ferr[i] = 1'b1; mdl_abort(i);
          end else begin
            m_word[i] = m_word[i] * 2 + bitv;
            m_nbits[i]++;
            m_phase[i] = P_DATA;
            if (m_nbits[i] == nb_of(i) + par_of(i)) begin
              if (par_of(i) == 1 && ($countones(m_word[i]) % 2) != 0) begin
                m_ferr[i] = 1'b1; mdl_abort(i);
              end else begin
                m_amp[i]   = (par_of(i) == 1) ? (m_word[i] >> 1) : m_word[i];
                m_valid[i] = 1'b1;
              end
            end
          end
        end
        P_ARM:   m_phase[i] = P_SCAN;
        P_SCAN:  m_phase[i] = P_FIRE;
        default: m_phase[i] = P_SCAN;
      endcase
    end else if ((m_phase[i] >= P_WAKE && m_phase[i] <= P_ARM && gap == 10) ||
                 ((m_phase[i] == P_SCAN || m_phase[i] == P_FIRE) && sto_of(i) != 0 &&
                  gap == sto_of(i))) begin
      m_tout[i] = 1'b1;
      mdl_abort(i);
    end
  endtask

  initial begin
    mdl_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) mdl_reset();
      else begin
        for (int i = 0; i < 3; i++) mdl_step(i);
        edge_n++;
      end
    end
  end

  // Cycle-by-cycle comparison of every output against the model.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        chk("state", i, int'(o_st[i]), st_of(m_phase[i]));
        chk("amplitude", i, amp_act(i), m_amp[i]);
        chk("amp_valid", i, int'(o_valid[i]), int'(m_valid[i]));
        chk("fire", i, int'(o_fire[i]), (m_phase[i] == P_FIRE) ? 1 : 0);
        chk("frame_err", i, int'(o_ferr[i]), int'(m_ferr[i]));
        chk("timeout", i, int'(o_tout[i]), int'(m_tout[i]));
        chk("rled", i, int'(o_led[i]), st_of(m_phase[i]));
        chk("gled5", i, int'(o_gled[i]), int'(m_valid[i]));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic send(input int i, input int g, input int exp_st);
    repeat (g - 1) @(negedge clk);
    d[i] = 1'b1;
    @(negedge clk);
    d[i] = 1'b0;
    chk("state_after_pulse", i, int'(o_st[i]), exp_st);
  endtask

  task automatic wake(input int i);
    send(i, 3, 1);
    send(i, 3, 1);
    send(i, 3, 3);
  endtask

  task automatic send_bit(input int i, input int b, input int last_exp);
    send(i, 3, 4);
    if (b != 0) begin send(i, 8, 5); send(i, 3, last_exp); end
    else begin send(i, 3, 5); send(i, 8, last_exp); end
  endtask

  task automatic send_word(input int i, input int val, input int n);
    for (int k = n - 1; k >= 0; k--) send_bit(i, (val >> k) & 1, 3);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_timeout(input int i, input int n, input int thr, input int st_before);
    int tcount;
    tcount = 0;
    for (int j = 1; j <= n; j++) begin
      @(negedge clk);
      if (o_tout[i]) tcount++;
      if (j == thr - 1) chk("pre_timeout_state", i, int'(o_st[i]), st_before);
      if (j == thr) chk("timeout_state", i, int'(o_st[i]), 0);
      if (j == thr) chk("timeout_pulse", i, int'(o_tout[i]), 1);
    end
    chk("timeout_count", i, tcount, 1);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) d[i] = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("reset_state", 0, int'(o_st[0]), 0);
    chk("reset_amp", 0, amp_act(0), 0);
    chk("reset_valid", 0, int'(o_valid[0]), 0);

    // Lone pulse times out ten cycles later; wake restarts cleanly afterwards.
    send(0, 3, 1);
    wait_timeout(0, 20, 10, 1);
    send(0, 2, 1);
    send(0, 3, 1);
    send(0, 3, 3);
    send_word(0, 6, 4);
    chk("amp_0110", 0, amp_act(0), 6);
    chk("valid_0110", 0, int'(o_valid[0]), 1);
    wait_timeout(0, 12, 10, 3);
    chk("amp_hold_after_timeout", 0, amp_act(0), 6);
    chk("valid_hold_after_timeout", 0, int'(o_valid[0]), 1);

    // Gap 5 is neither short nor long.
    wake(0);
    send(0, 3, 4);
    send(0, 5, 5);
    send(0, 3, 0);
    chk("ferr_pulse", 0, int'(o_ferr[0]), 1);
    chk("amp_kept_on_err", 0, amp_act(0), 6);
    @(negedge clk);
    chk("ferr_one_cycle", 0, int'(o_ferr[0]), 0);

    // Full default frame 1011 then arm/scan/fire/scan.
    do_reset();
    wake(0);
    send_word(0, 11, 4);
    chk("amp_1011", 0, amp_act(0), 11);
    chk("valid_1011", 0, int'(o_valid[0]), 1);
    send(0, 3, 7);
    send(0, 3, 8);
    chk("fire_scan", 0, int'(o_fire[0]), 0);
    send(0, 3, 9);
    chk("fire_in_fire", 0, int'(o_fire[0]), 1);
    send(0, 3, 8);
    chk("fire_rescan", 0, int'(o_fire[0]), 0);

    // Parity: bad parity first, then good parity.
    wake(1);
    send_word(1, 11, 4);
    send_bit(1, 0, 0);
    chk("par_bad_ferr", 1, int'(o_ferr[1]), 1);
    chk("par_bad_valid", 1, int'(o_valid[1]), 0);
    wake(1);
    send_word(1, 11, 4);
    send_bit(1, 1, 3);
    chk("par_ok_valid", 1, int'(o_valid[1]), 1);
    chk("par_ok_amp", 1, amp_act(1), 11);

    // 8-bit payload, then scan timeout of 30.
    wake(2);
    send_word(2, 165, 8);
    chk("amp_a5", 2, amp_act(2), 165);
    send(2, 3, 7);
    send(2, 3, 8);
    wait_timeout(2, 40, 30, 8);
    chk("scan_to_valid", 2, int'(o_valid[2]), 1);
    chk("scan_to_amp", 2, amp_act(2), 165);

    // Asynchronous reset while in SYM_C.
    wake(2);
    send(2, 3, 4);
    send(2, 8, 5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_state", 2, int'(o_st[2]), 0);
    chk("arst_amp", 2, amp_act(2), 0);
    chk("arst_valid", 2, int'(o_valid[2]), 0);
    chk("arst_fire", 2, int'(o_fire[2]), 0);
    chk("arst_ferr", 2, int'(o_ferr[2]), 0);
    chk("arst_tout", 2, int'(o_tout[2]), 0);
    chk("arst_led", 2, int'(o_led[2]), 0);
    chk("arst_gled", 2, int'(o_gled[2]), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
